// File: rtl/pwstepper.sv
// ============================================================================
// Module   : pwstepper
// Purpose  : Adds an arbitrary step to a password held as a bijective base-R
//            number over [CHAR_MIN..CHAR_MAX]. Processes one byte per clock
//            and stops as soon as the carry is zero.
// Config   : PWSTEPPER_WRAP_EN selects wrap-to-empty on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwstepper #(
    parameter int         MAX_LEN  = 20,
    parameter logic [7:0] CHAR_MIN = 8'h20,
    parameter logic [7:0] CHAR_MAX = 8'h7E,
    parameter int         STEP_W   = 8,
    localparam int        LEN_W    = $clog2(MAX_LEN + 2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*MAX_LEN-1:0]   in_password,
    input  logic [LEN_W-1:0]       in_length,
    input  logic [STEP_W-1:0]      in_step,
    input  logic                   trigger,
    output logic [8*MAX_LEN-1:0]   out_password,
    output logic [LEN_W-1:0]       out_length,
    output logic                   completed,
    output logic                   overflow
);

    localparam int               RADIX     = int'(CHAR_MAX) - int'(CHAR_MIN) + 1;
    localparam int               CW        = STEP_W + 1;
    localparam int               SW        = CW + 8;
    localparam logic [SW-1:0]    RADIX_V   = SW'(RADIX);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
`ifdef PWSTEPPER_WRAP_EN
    localparam logic [LEN_W-1:0] OVF_LEN   = '0;
`else
    localparam logic [LEN_W-1:0] OVF_LEN   = LEN_W'(MAX_LEN + 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [8*MAX_LEN-1:0] pw_q, pw_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic [CW-1:0]        carry_q, carry_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 trig_q;

    logic                 accept;
    logic [7:0]           cur_byte;
    logic [7:0]           new_byte;
    logic [SW-1:0]        digit;
    logic [SW-1:0]        sum;

    always_comb begin
        state_d  = state_q;
        pw_d     = pw_q;
        len_d    = len_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        done_d   = done_q;
        ovf_d    = ovf_q;

        accept   = trigger && !trig_q && (state_q != RUN);

        cur_byte = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == LEN_W'(i)) cur_byte = pw_q[8*i +: 8];
        end
        // Bytes outside the charset read as digit 0.
        digit = (cur_byte >= CHAR_MIN && cur_byte <= CHAR_MAX) ?
                SW'(cur_byte - CHAR_MIN) : '0;
        // Beyond the current length the bijective extension consumes one unit.
        if (idx_q < len_q) sum = digit + SW'(carry_q);
        else               sum = SW'(carry_q) - SW'(1);
        new_byte = CHAR_MIN + 8'(sum % RADIX_V);

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    pw_d    = in_password;
                    len_d   = in_length;
                    carry_d = {1'b0, in_step};
                    idx_d   = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((len_q > MAX_LEN_L) || (carry_q != '0 && idx_q == MAX_LEN_L)) begin
                    pw_d    = {MAX_LEN{CHAR_MIN}};
                    len_d   = OVF_LEN;
                    ovf_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (carry_q == '0) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (LEN_W'(i) >= len_q) pw_d[8*i +: 8] = CHAR_MIN;
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == LEN_W'(i)) pw_d[8*i +: 8] = new_byte;
                    end
                    carry_d = CW'(sum / RADIX_V);
                    if (idx_q >= len_q) len_d = idx_q + LEN_W'(1);
                    idx_d   = idx_q + LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pw_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            carry_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            trig_q  <= trigger;
        end
    end

    assign out_password = pw_q;
    assign out_length   = len_q;
    assign completed    = done_q;
    assign overflow     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pwstepper.sv
// ============================================================================
// Module   : tb_pwstepper
// Purpose  : Randomised and directed bench for pwstepper against a numeric
//            bijective base-95 reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwstepper;

    localparam int MAX_LEN = 20;
    localparam int LEN_W   = 5;
    localparam int RADIX   = 95;
`ifdef PWSTEPPER_WRAP_EN
    localparam int OVF_LEN = 0;
`else
    localparam int OVF_LEN = MAX_LEN + 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [8*MAX_LEN-1:0] in_password = '0;
    logic [LEN_W-1:0]     in_length = '0;
    logic [7:0]           in_step = '0;
    logic                 trigger = 1'b0;
    logic [8*MAX_LEN-1:0] out_password;
    logic [LEN_W-1:0]     out_length;
    logic                 completed;
    logic                 overflow;

    int n_vec = 0;
    int n_err = 0;

    pwstepper dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_password  (in_password),
        .in_length    (in_length),
        .in_step      (in_step),
        .trigger      (trigger),
        .out_password (out_password),
        .out_length   (out_length),
        .completed    (completed),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Password as an integer: value = sum (d_i + 1) * 95^i, then add and re-digitise.
    function automatic void model(input logic [159:0] pw, input int len, input int step,
                                  output logic [159:0] epw, output int elen,
                                  output bit eovf, output int p);
        logic [191:0] v, pw95, dsum;
        int nl;
        int dig[MAX_LEN];
        epw  = {MAX_LEN{8'h20}};
        eovf = 1'b0;
        p    = 0;
        elen = 0;
        if (len > MAX_LEN) begin
            eovf = 1'b1;
            elen = OVF_LEN;
            return;
        end
        v    = '0;
        pw95 = 192'd1;
        for (int i = 0; i < len; i++) begin
            v    = v + 192'(pw[8*i +: 8] - 8'h20 + 8'd1) * pw95;
            pw95 = pw95 * RADIX;
        end
        v  = v + 192'(step);
        nl = 0;
        while (v != '0) begin
            if (nl == MAX_LEN) begin
                eovf = 1'b1;
                break;
            end
            v       = v - 192'd1;
            dig[nl] = int'(v % RADIX);
            v       = v / RADIX;
            nl++;
        end
        if (eovf) begin
            elen = OVF_LEN;
            p    = MAX_LEN;
            return;
        end
        elen = nl;
        for (int i = 0; i < nl; i++) epw[8*i +: 8] = 8'(8'h20 + dig[i]);
        if (nl > len) begin
            p = nl;
        end else begin
            // Positions touched = first k where the low k digits absorb the step.
            dsum = '0;
            pw95 = 192'd1;
            p    = len;
            for (int k = 0; k <= len; k++) begin
                if (dsum + 192'(step) < pw95) begin
                    p = k;
                    break;
                end
                if (k < len) begin
                    dsum = dsum + 192'(pw[8*k +: 8] - 8'h20) * pw95;
                    pw95 = pw95 * RADIX;
                end
            end
        end
    endfunction

    task automatic run(input string tag, input logic [159:0] pw, input int len,
                       input int step, input int pulse_at);
        logic [159:0] epw;
        int elen, p, n;
        bit eovf;
        model(pw, len, step, epw, elen, eovf, p);
        @(negedge clk);
        in_password = pw;
        in_length   = LEN_W'(len);
        in_step     = 8'(step);
        trigger     = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        check({tag, ".busy"}, 192'(completed), 192'(0));
        n = 0;
        while (!completed && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            trigger = (n == pulse_at);
        end
        trigger = 1'b0;
        check({tag, ".done"}, 192'(completed), 192'(1));
        check({tag, ".lat"},  192'(n),         192'(p + 1));
        check({tag, ".len"},  192'(out_length), 192'(elen));
        check({tag, ".pw"},   192'(out_password), 192'(epw));
        check({tag, ".ovf"},  192'(overflow),  192'(eovf));
    endtask

    initial begin
        logic [159:0] pw;
        int len;

        #12;
        check("rst.pw",   192'(out_password), 192'(0));
        check("rst.len",  192'(out_length), 192'(0));
        check("rst.done", 192'(completed), 192'(0));
        check("rst.ovf",  192'(overflow), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;

        pw = {MAX_LEN{8'h20}};
        run("len0_step1", pw, 0, 1, -1);
        pw[7:0] = 8'h7E;
        run("carry1", pw, 1, 1, -1);
        pw[15:0] = 16'h207E;
        run("carry2", pw, 2, 1, -1);
        pw = {MAX_LEN{8'h20}};
        pw[31:0] = 32'h54455354;
        run("step95", pw, 4, 95, -1);
        pw = {MAX_LEN{8'h20}};
        run("step200", pw, 1, 200, -1);
        pw = {MAX_LEN{8'h7E}};
        run("max_ovf", pw, 20, 1, -1);
        pw = {MAX_LEN{8'h41}};
        run("len21", pw, 21, 5, -1);
        run("step0", pw, 5, 0, -1);
        pw = {MAX_LEN{8'h7E}};
        run("trig_in_run", pw, 20, 1, 3);

        // Reset in the middle of a long run.
        @(negedge clk);
        in_password = {MAX_LEN{8'h7E}};
        in_length   = LEN_W'(20);
        in_step     = 8'd1;
        trigger     = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.pw",   192'(out_password), 192'(0));
        check("midrst.len",  192'(out_length), 192'(0));
        check("midrst.done", 192'(completed), 192'(0));
        check("midrst.ovf",  192'(overflow), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;
        pw = {MAX_LEN{8'h20}};
        pw[23:0] = 24'h7E7E7E;
        run("after_rst", pw, 3, 1, -1);

        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(0, MAX_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i >= len)       pw[8*i +: 8] = 8'($urandom_range(0, 255));
                else if (t % 5 == 0) pw[8*i +: 8] = 8'h7E - 8'($urandom_range(0, 1));
                else                pw[8*i +: 8] = 8'(8'h20 + $urandom_range(0, 94));
            end
            run($sformatf("rnd%0d", t), pw, len, $urandom_range(0, 255), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
